// File: rtl/conv_mul_arbiter_if.sv
// Requester, multiplier and result bundle for conv_mul_arbiter.
// slave is the arbiter side, master is the environment side.
interface conv_mul_arbiter_if #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned OPERAND_WIDTH = 16,
    parameter int unsigned PRODUCT_WIDTH = 32
);
    localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*OPERAND_WIDTH-1:0] req_a;
    logic [NUM_REQ*OPERAND_WIDTH-1:0] req_b;
    logic [OPERAND_WIDTH-1:0]         mul_din0;
    logic [OPERAND_WIDTH-1:0]         mul_din1;
    logic [PRODUCT_WIDTH-1:0]         mul_dout;
    logic                             rsp_valid;
    logic                             rsp_ready;
    logic [PRODUCT_WIDTH-1:0]         rsp_data;
    logic [ID_WIDTH-1:0]              rsp_id;
    logic [31:0]                      op_count;

    modport slave (
        input  req_valid, req_a, req_b, mul_dout, rsp_ready,
        output req_ready, mul_din0, mul_din1, rsp_valid, rsp_data, rsp_id, op_count
    );

    modport master (
        output req_valid, req_a, req_b, mul_dout, rsp_ready,
        input  req_ready, mul_din0, mul_din1, rsp_valid, rsp_data, rsp_id, op_count
    );
endinterface

// File: rtl/conv_mul_arbiter.sv
// Round-robin arbiter sharing one external combinational multiplier among
// NUM_REQ requesters, with a single registered result slot.
module conv_mul_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned OPERAND_WIDTH = 16,
    parameter int unsigned PRODUCT_WIDTH = 32
) (
    input  logic ap_clk,
    input  logic ap_rst,
    conv_mul_arbiter_if.slave bus
);
    localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                   state;
    logic                     rsp_valid_q;
    logic [PRODUCT_WIDTH-1:0] rsp_data_q;
    logic [ID_WIDTH-1:0]      rsp_id_q;
    logic [ID_WIDTH-1:0]      ptr;
    logic [31:0]              op_count_q;

    logic                     slot_free;
    logic                     found;
    logic                     grant;
    logic [ID_WIDTH-1:0]      gnt_idx;
    logic [ID_WIDTH-1:0]      nxt_ptr;
    logic [ID_WIDTH-1:0]      sel;

    // Reset gates the slot so nothing can be accepted while ap_rst is high.
    assign slot_free = !ap_rst && ((state == EMPTY) || (rsp_valid_q && bus.rsp_ready));
    assign grant     = slot_free && found;
    assign nxt_ptr   = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign sel       = grant ? gnt_idx : ptr;

    // First valid requester at or after ptr, wrapping at NUM_REQ.
    always_comb begin : pick
        int unsigned sum;
        logic [ID_WIDTH-1:0] cand;
        sum     = 0;
        cand    = '0;
        found   = 1'b0;
        gnt_idx = ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = 32'(ptr) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = ID_WIDTH'(sum);
            if (!found && bus.req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin : ready_gen
        bus.req_ready = '0;
        if (grant) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin : operand_mux
        bus.mul_din0 = bus.req_a[OPERAND_WIDTH-1:0];
        bus.mul_din1 = bus.req_b[OPERAND_WIDTH-1:0];
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel == ID_WIDTH'(i)) begin
                bus.mul_din0 = bus.req_a[i*OPERAND_WIDTH +: OPERAND_WIDTH];
                bus.mul_din1 = bus.req_b[i*OPERAND_WIDTH +: OPERAND_WIDTH];
            end
        end
    end

    // A grant takes priority over a plain consume so back-to-back accepts stay FULL.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= EMPTY;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            ptr         <= '0;
            op_count_q  <= '0;
        end else if (grant) begin
            state       <= FULL;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.mul_dout;
            rsp_id_q    <= gnt_idx;
            ptr         <= nxt_ptr;
            op_count_q  <= op_count_q + 32'd1;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            state       <= EMPTY;
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_conv_mul_arbiter.sv
// Directed bench for conv_mul_arbiter: expected responses are queued by the
// stimulus and popped by a monitor whenever a result is handed over.
module tb_conv_mul_arbiter;
    localparam int unsigned N = 4;
    localparam int unsigned W = 16;
    localparam int unsigned P = 32;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;

    conv_mul_arbiter_if #(.NUM_REQ(N), .OPERAND_WIDTH(W), .PRODUCT_WIDTH(P)) bus ();

    conv_mul_arbiter #(.NUM_REQ(N), .OPERAND_WIDTH(W), .PRODUCT_WIDTH(P)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    always #5 ap_clk = ~ap_clk;

    // Shared multiplier lives outside the arbiter.
    assign bus.mul_dout = P'(bus.mul_din0) * P'(bus.mul_din1);

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic expect_rsp(input logic [1:0] id, input logic [31:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sbq.push_back(e);
    endtask

    always @(negedge ap_clk) begin : monitor
        exp_t e;
        if (!ap_rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got id=%0d data=0x%0h expected no response",
                         bus.rsp_id, bus.rsp_data);
            end else begin
                e = sbq.pop_front();
                check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
            end
        end
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    logic [3:0]  rr_ready [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0]  rr_id    [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] rr_prod  [5] = '{32'd14, 32'd24, 32'd36, 32'd50, 32'd14};

    initial begin : stimulus
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        ap_rst        = 1'b1;
        repeat (2) cyc();

        // Nothing accepted during reset even with every requester valid.
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        settle();
        check("ready_in_reset", 64'(bus.req_ready), 64'(0));
        cyc();
        ap_rst        = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        settle();
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("reset_rsp_data", 64'(bus.rsp_data), 64'(0));
        check("reset_rsp_id", 64'(bus.rsp_id), 64'(0));
        check("reset_op_count", 64'(bus.op_count), 64'(0));

        // Single request, one-cycle latency.
        set_op(0, 16'd3, 16'd5);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        expect_rsp(2'd0, 32'd15);
        settle();
        check("single_ready", 64'(bus.req_ready), 64'(4'b0001));
        check("single_din0", 64'(bus.mul_din0), 64'(3));
        check("single_din1", 64'(bus.mul_din1), 64'(5));
        cyc();
        bus.req_valid = '0;
        settle();
        check("single_valid", 64'(bus.rsp_valid), 64'(1));
        check("single_data", 64'(bus.rsp_data), 64'(15));
        check("single_id", 64'(bus.rsp_id), 64'(0));
        check("single_count", 64'(bus.op_count), 64'(1));
        cyc();
        settle();
        check("drain_valid", 64'(bus.rsp_valid), 64'(0));
        check("drain_data_kept", 64'(bus.rsp_data), 64'(15));

        // Round robin from index 0 with all requesters valid, no bubbles.
        ap_rst = 1'b1;
        cyc();
        ap_rst = 1'b0;
        set_op(0, 16'd2, 16'd7);
        set_op(1, 16'd3, 16'd8);
        set_op(2, 16'd4, 16'd9);
        set_op(3, 16'd5, 16'd10);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            expect_rsp(rr_id[c], rr_prod[c]);
            settle();
            check("rr_ready", 64'(bus.req_ready), 64'(rr_ready[c]));
            check("rr_valid", 64'(bus.rsp_valid), (c > 0) ? 64'(1) : 64'(0));
            cyc();
        end
        bus.req_valid = '0;
        settle();
        check("rr_last_valid", 64'(bus.rsp_valid), 64'(1));
        check("rr_count", 64'(bus.op_count), 64'(5));
        cyc();
        settle();
        check("rr_drained", 64'(bus.rsp_valid), 64'(0));

        // Backpressure: FULL with rsp_ready low blocks all grants.
        set_op(1, 16'd6, 16'd7);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        expect_rsp(2'd1, 32'd42);
        settle();
        check("bp_first_ready", 64'(bus.req_ready), 64'(4'b0010));
        cyc();
        set_op(2, 16'hFFFF, 16'hFFFF);
        bus.req_valid = 4'b1111;
        repeat (3) begin
            settle();
            check("bp_ready", 64'(bus.req_ready), 64'(0));
            check("bp_valid", 64'(bus.rsp_valid), 64'(1));
            check("bp_data", 64'(bus.rsp_data), 64'(42));
            check("bp_id", 64'(bus.rsp_id), 64'(1));
            cyc();
        end
        bus.rsp_ready = 1'b1;
        expect_rsp(2'd2, 32'hFFFE_0001);
        settle();
        check("bp_release_ready", 64'(bus.req_ready), 64'(4'b0100));
        check("max_din0", 64'(bus.mul_din0), 64'(16'hFFFF));
        cyc();
        bus.req_valid = '0;
        settle();
        check("max_data", 64'(bus.rsp_data), 64'(32'hFFFE_0001));
        check("max_id", 64'(bus.rsp_id), 64'(2));
        cyc();

        // Reset while FULL with ptr=2, then again with ptr=3.
        set_op(1, 16'd2, 16'd2);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        settle();
        check("wrap_search_ready", 64'(bus.req_ready), 64'(4'b0010));
        cyc();
        check("pre_reset_count", 64'(bus.op_count), 64'(8));
        ap_rst        = 1'b1;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        settle();
        check("ready_in_reset_full", 64'(bus.req_ready), 64'(0));
        cyc();
        ap_rst        = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1100;
        set_op(2, 16'd9, 16'd11);
        settle();
        check("mid_reset_valid", 64'(bus.rsp_valid), 64'(0));
        check("mid_reset_count", 64'(bus.op_count), 64'(0));
        check("mid_reset_ready", 64'(bus.req_ready), 64'(4'b0100));
        cyc();
        bus.req_valid = '0;
        settle();
        check("post_reset_data", 64'(bus.rsp_data), 64'(99));
        check("post_reset_id", 64'(bus.rsp_id), 64'(2));
        check("post_reset_count", 64'(bus.op_count), 64'(1));
        ap_rst = 1'b1;
        cyc();
        ap_rst        = 1'b0;
        bus.req_valid = 4'b1100;
        bus.rsp_ready = 1'b1;
        expect_rsp(2'd2, 32'd99);
        settle();
        check("ptr_reset_ready", 64'(bus.req_ready), 64'(4'b0100));
        cyc();
        bus.req_valid = '0;
        settle();
        check("ptr_reset_count", 64'(bus.op_count), 64'(1));
        cyc();

        // op_count wrap from all-ones.
        force dut.op_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.op_count_q;
        check("count_preload", 64'(bus.op_count), 64'(32'hFFFF_FFFF));
        set_op(3, 16'd100, 16'd300);
        bus.req_valid = 4'b1000;
        expect_rsp(2'd3, 32'd30000);
        settle();
        check("wrap_ready", 64'(bus.req_ready), 64'(4'b1000));
        cyc();
        bus.req_valid = '0;
        settle();
        check("count_wrap", 64'(bus.op_count), 64'(0));
        cyc();
        settle();
        check("sb_drained", 64'(sbq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
